// File: rtl/apb_master_bridge_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  tmo;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response side plus APB bus signals of the bridge.
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_tmo;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  // Bridge side: takes commands, drives the APB requester signals.
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    output paddr, psel, penable, pwrite, pwdata
  );

  // Environment side: command source and APB completer.
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
    input  paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master_bridge_timer.sv
// Wait-state watchdog: counts ACCESS cycles with pready low.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: valid/ready command -> SETUP/ACCESS transfer -> one response.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic pclk,
  input  logic rst,
  apb_master_bridge_if.master bus
);
  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_tmo_q, rsp_tmo_d;
  logic              cmd_ready;
  logic              tmr_clr, tmr_en, tmr_expired;

  assign cmd_ready = (state_q == APB_IDLE) && !rst;
  assign tmr_en    = (state_q == APB_ACCESS) && !bus.pready;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (pclk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expired_o(tmr_expired)
  );

  // Next state, captured command and response; APB strobes follow the next state.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    tmr_clr     = 1'b0;
    case (state_q)
      APB_IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          if (bus.cmd_write) pwdata_d = bus.cmd_wdata;
          tmr_clr  = 1'b1;
          state_d  = APB_SETUP;
        end
      end
      APB_SETUP: state_d = APB_ACCESS;
      APB_ACCESS: begin
        // pready is checked first so a completion on the timeout cycle is not aborted
        if (bus.pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d   = bus.pslverr;
          rsp_tmo_d   = 1'b0;
          state_d     = APB_IDLE;
        end else if (tmr_expired) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          state_d     = APB_IDLE;
        end
      end
      default: state_d = APB_IDLE;
    endcase
    psel_d    = (state_d != APB_IDLE);
    penable_d = (state_d == APB_ACCESS);
  end

  // State and registered outputs.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= APB_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tmo   = rsp_tmo_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a wait-state APB completer.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int TMO = 16;

  typedef struct {
    apb_cmd_t    cmd;
    int          wt;
    logic        er;
    logic [31:0] e_rd;
    logic        e_err;
    logic        e_tmo;
    int          e_lat;
  } vec_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cur_wait = 0;
  logic cur_err  = 1'b0;
  int   acc_cnt  = 0;
  logic [31:0] smem    [0:255];
  logic [31:0] ref_mem [0:255];
  vec_t vecs [$];

  apb_master_bridge_if bus ();

  apb_master_bridge #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 pclk = ~pclk;

  // Completer: pready after cur_wait low ACCESS cycles; noise on inputs outside ACCESS.
  always @(negedge pclk) begin
    if (bus.psel && bus.penable) begin
      bus.pready  = (acc_cnt == cur_wait);
      bus.prdata  = smem[bus.paddr];
      bus.pslverr = cur_err;
      acc_cnt++;
    end else begin
      bus.pready  = 1'($urandom_range(0, 1));
      bus.prdata  = $urandom;
      bus.pslverr = 1'($urandom_range(0, 1));
      acc_cnt     = 0;
    end
  end

  // Completer storage: a write lands only when it completes without pslverr.
  always @(posedge pclk) begin
    if (!rst && bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslverr)
      smem[bus.paddr] <= bus.pwdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                              input int wt, input logic er, input logic [31:0] rd,
                              input logic e_err, input logic e_tmo, input int lat);
    vec_t v;
    v.cmd.write = wr; v.cmd.addr = a; v.cmd.wdata = wd;
    v.wt = wt; v.er = er; v.e_rd = rd; v.e_err = e_err; v.e_tmo = e_tmo; v.e_lat = lat;
    return v;
  endfunction

  task automatic do_xfer(input vec_t v, input string nm);
    int   lat = 0;
    bit   got = 0;
    bit   bus_ok = 1;
    bit   acc_ok = 0;
    logic [31:0] rd_hold;
    @(negedge pclk);
    cur_wait = v.wt; cur_err = v.er;
    bus.cmd_valid = 1'b1; bus.cmd_write = v.cmd.write;
    bus.cmd_addr = v.cmd.addr; bus.cmd_wdata = v.cmd.wdata;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin acc_ok = 1; break; end
      @(negedge pclk);
    end
    chk({nm, "_accept"}, 32'(acc_ok), 32'd1);
    @(posedge pclk);
    #1 bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge pclk);
      lat = k;
      if (bus.rsp_valid) begin
        got = 1;
        if (bus.psel || bus.penable) bus_ok = 0;
        break;
      end
      if (!bus.psel || (bus.penable != (k > 1)) || (bus.paddr != v.cmd.addr) ||
          (bus.pwrite != v.cmd.write) || (v.cmd.write && bus.pwdata != v.cmd.wdata))
        bus_ok = 0;
    end
    chk({nm, "_rsp_seen"}, 32'(got), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(v.e_lat));
    chk({nm, "_bus_seq"}, 32'(bus_ok), 32'd1);
    chk({nm, "_rdata"}, bus.rsp_rdata, v.e_rd);
    chk({nm, "_err"}, 32'(bus.rsp_err), 32'(v.e_err));
    chk({nm, "_tmo"}, 32'(bus.rsp_tmo), 32'(v.e_tmo));
    rd_hold = bus.rsp_rdata;
    @(negedge pclk);
    chk({nm, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, "_hold"}, bus.rsp_rdata, rd_hold);
  endtask

  initial begin
    int   acc_at [$];
    bit   no_rsp;
    vec_t v;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
    for (int i = 0; i < 256; i++) begin smem[i] = '0; ref_mem[i] = '0; end

    // Reset values
    #3;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_paddr", 32'(bus.paddr), 32'd0);
    repeat (2) @(negedge pclk);
    rst = 1'b0;

    // Directed table
    vecs.push_back(mk(1, 8'h10, 32'hDEADBEEF, 0,    0, 32'h0,        0, 0, 3));
    vecs.push_back(mk(0, 8'h10, 32'h0,        0,    0, 32'hDEADBEEF, 0, 0, 3));
    vecs.push_back(mk(1, 8'h20, 32'h12345678, 3,    0, 32'h0,        0, 0, 6));
    vecs.push_back(mk(0, 8'h20, 32'h0,        3,    0, 32'h12345678, 0, 0, 6));
    vecs.push_back(mk(0, 8'h10, 32'h0,        1000, 0, 32'h0,        1, 1, 18));
    vecs.push_back(mk(0, 8'h10, 32'h0,        0,    1, 32'hDEADBEEF, 1, 0, 3));
    vecs.push_back(mk(0, 8'h20, 32'h0,        15,   0, 32'h12345678, 0, 0, 18));
    vecs.push_back(mk(0, 8'h20, 32'h0,        16,   0, 32'h0,        1, 1, 18));
    vecs.push_back(mk(1, 8'h10, 32'h55AA55AA, 0,    1, 32'h0,        1, 0, 3));
    vecs.push_back(mk(0, 8'h10, 32'h0,        2,    0, 32'hDEADBEEF, 0, 0, 5));
    for (int i = 0; i < vecs.size(); i++) do_xfer(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of ACCESS
    @(negedge pclk);
    cur_wait = 1000; cur_err = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h10;
    @(posedge pclk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    chk("mid_in_access", 32'(bus.psel && bus.penable), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_psel", 32'(bus.psel), 32'd0);
    chk("mid_rst_penable", 32'(bus.penable), 32'd0);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    no_rsp = 1;
    repeat (2) begin @(negedge pclk); if (bus.rsp_valid) no_rsp = 0; end
    rst = 1'b0;
    repeat (4) begin @(negedge pclk); if (bus.rsp_valid) no_rsp = 0; end
    chk("mid_rst_no_rsp", 32'(no_rsp), 32'd1);
    do_xfer(mk(0, 8'h10, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0, 3), "after_rst");

    // cmd_valid held high: acceptance every third cycle
    @(negedge pclk);
    cur_wait = 0; cur_err = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'h30; bus.cmd_wdata = 32'hCAFEF00D;
    for (int k = 0; k < 10; k++) begin
      if (bus.cmd_ready) acc_at.push_back(k);
      @(negedge pclk);
    end
    bus.cmd_valid = 1'b0;
    repeat (4) @(negedge pclk);
    chk("b2b_count_ge3", 32'(acc_at.size() >= 3), 32'd1);
    if (acc_at.size() >= 3) begin
      chk("b2b_gap1", 32'(acc_at[1] - acc_at[0]), 32'd3);
      chk("b2b_gap2", 32'(acc_at[2] - acc_at[1]), 32'd3);
    end

    // Random transfers against a reference memory model
    for (int n = 0; n < 40; n++) begin
      logic       wr = 1'($urandom_range(0, 1));
      logic [7:0] a  = 8'(8'h40 + $urandom_range(0, 15));
      int         wt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(13, 20))
                                                   : int'($urandom_range(0, 3));
      logic       er = ($urandom_range(0, 7) == 0);
      v = mk(wr, a, $urandom, wt, er, 32'h0, 0, 0, 0);
      if (wt >= TMO) begin
        v.e_err = 1; v.e_tmo = 1; v.e_rd = '0; v.e_lat = 2 + TMO;
      end else begin
        v.e_err = er; v.e_tmo = 0; v.e_lat = 3 + wt;
        v.e_rd  = wr ? 32'h0 : ref_mem[a];
        if (wr && !er) ref_mem[a] = v.cmd.wdata;
      end
      do_xfer(v, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
